// File: rtl/mac_job_sched_pkg.sv
// Shared types and defaults for the MAC job scheduler.
package mac_package;

    localparam int DEF_N_CONTEXT = 2;
    localparam int SCHED_OWN_W   = 8;
    localparam int SCHED_JOB_W   = 32;

    typedef enum logic [1:0] {
        SCHED_IDLE,
        SCHED_START,
        SCHED_RUN
    } sched_state_t;

    typedef struct packed {
        logic [SCHED_OWN_W-1:0] owner;
        logic [SCHED_JOB_W-1:0] job;
    } sched_entry_t;

endpackage

// File: rtl/mac_job_sched_fifo.sv
// Synchronous FIFO of pending scheduler entries; head is read combinationally.
module mac_job_fifo
    import mac_package::*;
#(
    parameter int  DEPTH   = DEF_N_CONTEXT,
    parameter int  CNT_W   = $clog2(DEPTH + 1),
    parameter type entry_t = sched_entry_t
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push,
    input  entry_t           wdata,
    input  logic             pop,
    output entry_t           rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/mac_job_sched.sv
// Round-robin job scheduler sharing one MAC engine between several cores.
module mac_job_sched
    import mac_package::*;
#(
    parameter  int N_CORES   = 2,
    parameter  int N_CONTEXT = DEF_N_CONTEXT,
    parameter  int JOB_W     = 32,
    localparam int OWN_W     = (N_CORES > 1) ? $clog2(N_CORES) : 1,
    localparam int CNT_W     = $clog2(N_CONTEXT + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic [N_CORES-1:0]       req_valid_i,
    input  logic [N_CORES*JOB_W-1:0] req_job_i,
    output logic [N_CORES-1:0]       req_ready_o,
    output logic                     start_o,
    output logic [JOB_W-1:0]         job_o,
    output logic [OWN_W-1:0]         owner_o,
    input  logic                     done_i,
    output logic [N_CORES-1:0]       evt_o,
    output logic                     busy_o,
    output logic [CNT_W-1:0]         pending_o
);

    typedef struct packed {
        logic [OWN_W-1:0] owner;
        logic [JOB_W-1:0] job;
    } entry_t;

    sched_state_t       state_q;
    sched_state_t       state_d;
    logic [N_CORES-1:0] grant;
    logic [OWN_W-1:0]   gidx;
    logic [OWN_W-1:0]   rr_q;
    logic               push;
    logic               pop;
    logic               empty;
    logic               full;
    entry_t             wdata;
    entry_t             head;
    logic [N_CORES-1:0] evt_d;

    // First requester at or after the pointer wins; a full queue blocks all.
    always_comb begin
        grant = '0;
        gidx  = '0;
        for (int i = 0; i < N_CORES; i++) begin
            int idx;
            idx = (int'(rr_q) + i) % N_CORES;
            if (!full && grant == '0 && req_valid_i[idx]) begin
                grant[idx] = 1'b1;
                gidx       = OWN_W'(idx);
            end
        end
    end

    assign push        = |grant;
    assign req_ready_o = grant;
    assign wdata.owner = gidx;
    assign wdata.job   = req_job_i[int'(gidx)*JOB_W +: JOB_W];

    mac_job_fifo #(
        .DEPTH   (N_CONTEXT),
        .CNT_W   (CNT_W),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .push    (push),
        .wdata   (wdata),
        .pop     (pop),
        .rdata   (head),
        .count   (pending_o),
        .empty   (empty),
        .full    (full)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        evt_d   = '0;
        unique case (state_q)
            SCHED_IDLE: begin
                if (!empty) begin
                    state_d = SCHED_START;
                    pop     = 1'b1;
                end
            end
            SCHED_START: state_d = SCHED_RUN;
            SCHED_RUN: begin
                if (done_i) begin
                    state_d        = SCHED_IDLE;
                    evt_d[owner_o] = 1'b1;
                end
            end
            default: state_d = SCHED_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q <= SCHED_IDLE;
            rr_q    <= '0;
            job_o   <= '0;
            owner_o <= '0;
            start_o <= 1'b0;
            evt_o   <= '0;
        end else begin
            state_q <= state_d;
            start_o <= pop;
            evt_o   <= evt_d;
            if (push) begin
                rr_q <= (gidx == OWN_W'(N_CORES - 1)) ? '0 : gidx + 1'b1;
            end
            if (pop) begin
                job_o   <= head.job;
                owner_o <= head.owner;
            end
        end
    end

    assign busy_o = (state_q != SCHED_IDLE) || !empty;

endmodule

// File: tb/tb_mac_job_sched.sv
// Randomized and directed checks of mac_job_sched against a queue-level model.
module tb_mac_job_sched;

    localparam int NC   = 2;
    localparam int NCTX = 4;
    localparam int JW   = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             done;
    logic [NC-1:0]    rv;
    logic [NC-1:0]    rdy;
    logic [NC-1:0]    evt;
    logic [NC*JW-1:0] rj;
    logic             st;
    logic [JW-1:0]    job;
    logic [0:0]       own;
    logic             busy;
    logic [2:0]       pend;

    always #5 clk = ~clk;

    mac_job_sched #(
        .N_CORES   (NC),
        .N_CONTEXT (NCTX),
        .JOB_W     (JW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clr),
        .req_valid_i (rv),
        .req_job_i   (rj),
        .req_ready_o (rdy),
        .start_o     (st),
        .job_o       (job),
        .owner_o     (own),
        .done_i      (done),
        .evt_o       (evt),
        .busy_o      (busy),
        .pending_o   (pend)
    );

    typedef struct {
        int          owner;
        logic [JW-1:0] job;
    } ent_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model: queue of pending jobs plus the job occupying the engine
    ent_t          mq[$];
    int            m_rr;
    bit            m_act;
    int            m_age;
    logic [JW-1:0] m_job;
    int            m_own;
    logic [NC-1:0] m_evt;

    // requester / engine stimulus for the next cycle
    logic [NC-1:0] v;
    logic [JW-1:0] jv [NC];
    bit            d_r;
    bit            rst_r;
    bit            clr_r;

    int starts[$];
    int gq[$];
    int evt_cnt [NC];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [NC-1:0] m_grant(input logic [NC-1:0] val);
        logic [NC-1:0] g;
        g = '0;
        if (mq.size() < NCTX) begin
            for (int i = 0; i < NC; i++) begin
                int idx;
                idx = (m_rr + i) % NC;
                if (g == '0 && val[idx]) g[idx] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic m_reset();
        mq.delete();
        m_rr  = 0;
        m_act = 0;
        m_age = 0;
        m_job = '0;
        m_own = 0;
        m_evt = '0;
    endtask

    task automatic m_edge(input logic [NC-1:0] g);
        bit            popping;
        bit            fin;
        logic [NC-1:0] ne;
        ent_t          e;
        if (rst_r || clr_r) begin
            m_reset();
        end else begin
            popping = !m_act && mq.size() > 0;
            fin     = m_act && m_age >= 1 && d_r;
            ne      = '0;
            if (fin) begin
                m_act     = 0;
                ne[m_own] = 1'b1;
            end else if (m_act) begin
                m_age++;
            end
            if (popping) begin
                e     = mq.pop_front();
                m_job = e.job;
                m_own = e.owner;
                m_act = 1;
                m_age = 0;
            end
            for (int k = 0; k < NC; k++) begin
                if (g[k]) begin
                    e.owner = k;
                    e.job   = jv[k];
                    mq.push_back(e);
                    m_rr = (k + 1) % NC;
                end
            end
            m_evt = ne;
        end
    endtask

    // one clock: drive, compare every output against the model, advance
    task automatic step();
        logic [NC-1:0] g;
        @(negedge clk);
        rv   = v;
        done = d_r;
        rst  = rst_r;
        clr  = clr_r;
        for (int k = 0; k < NC; k++) rj[k*JW +: JW] = jv[k];
        #1;
        g = m_grant(v);
        chk("ready", rdy, g);
        chk("start", st, (m_act && m_age == 0) ? 1 : 0);
        chk("job", job, m_job);
        chk("owner", own, m_own);
        chk("evt", evt, m_evt);
        chk("busy", busy, (m_act || mq.size() > 0) ? 1 : 0);
        chk("pending", pend, mq.size());
        if (st === 1'b1) starts.push_back(cyc);
        for (int k = 0; k < NC; k++) begin
            if (rdy[k] && rv[k]) gq.push_back(k);
            if (evt[k]) evt_cnt[k]++;
        end
        @(posedge clk);
        m_edge(g);
        if (!(rst_r || clr_r)) v = v & ~g;
        cyc++;
        d_r   = 0;
        rst_r = 0;
        clr_r = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push3();
        v     = 2'b11;
        jv[0] = 32'h0000_0100;
        jv[1] = 32'h0000_0201;
        step();
        v[0]  = 1'b1;
        jv[0] = 32'h0000_0102;
        step();
        step();
    endtask

    initial begin
        v     = '0;
        d_r   = 0;
        rst_r = 0;
        clr_r = 0;
        for (int k = 0; k < NC; k++) begin
            jv[k]      = '0;
            evt_cnt[k] = 0;
        end
        rst  = 1'b1;
        clr  = 1'b0;
        done = 1'b0;
        rv   = '0;
        rj   = '0;
        repeat (2) @(posedge clk);
        m_reset();
        rst_r = 1;
        step();
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_pending", pend, 0);
        chk("reset_start", st, 0);

        // single job from core 1
        v     = 2'b10;
        jv[1] = 32'h0000_00A5;
        step();
        #1;
        chk("single_pend", pend, 1);
        step();
        #1;
        chk("single_start", st, 1);
        chk("single_job", job, 32'hA5);
        chk("single_owner", own, 1);
        idle(8);
        d_r = 1;
        step();
        #1;
        chk("single_evt", evt, 2'b10);
        step();
        #1;
        chk("single_idle", busy, 0);

        // spurious done in IDLE and in START
        d_r = 1;
        step();
        #1;
        chk("spur_idle_evt", evt, 0);
        v     = 2'b01;
        jv[0] = 32'h0000_0011;
        step();
        step();
        d_r = 1;
        step();
        #1;
        chk("spur_start_evt", evt, 0);
        idle(3);
        d_r = 1;
        step();
        step();

        // fairness with a stalled engine
        rst_r = 1;
        step();
        gq.delete();
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < NC; k++) begin
                if (!v[k]) begin
                    v[k]  = 1'b1;
                    jv[k] = 32'h1000 * (k + 1) + i;
                end
            end
            step();
        end
        #1;
        chk("fair_g0", gq[0], 0);
        chk("fair_g1", gq[1], 1);
        chk("fair_g2", gq[2], 0);
        chk("fair_g3", gq[3], 1);
        chk("fair_full", pend, 4);
        chk("fair_noready", rdy, 0);

        // full queue with pops refilled in the following cycle
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < NC; k++) begin
                if (!v[k]) begin
                    v[k]  = 1'b1;
                    jv[k] = 32'h2000 * (k + 1) + i;
                end
            end
            d_r = (i % 4 == 3);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < NC; k++) begin
                if (!v[k]) begin
                    v[k]  = 1'b1;
                    jv[k] = 32'h3000 * (k + 1) + i;
                end
            end
            step();
        end
        #1;
        chk("refill_full", pend, 4);

        // reset and clear during RUN with two queued jobs
        for (int r = 0; r < 2; r++) begin
            v     = '0;
            rst_r = 1;
            step();
            push3();
            #1;
            chk("midrun_pend", pend, 2);
            if (r == 0) rst_r = 1;
            else        clr_r = 1;
            step();
            #1;
            chk("midrun_busy", busy, 0);
            chk("midrun_pend0", pend, 0);
            chk("midrun_job", job, 0);
            starts.delete();
            idle(10);
            chk("midrun_nostart", starts.size(), 0);
        end

        // back-to-back jobs with immediate done
        rst_r = 1;
        step();
        starts.delete();
        evt_cnt[0] = 0;
        evt_cnt[1] = 0;
        push3();
        for (int i = 0; i < 12; i++) begin
            d_r = (starts.size() > 0 && starts[$] == cyc - 1);
            step();
        end
        chk("b2b_nstart", starts.size(), 3);
        if (starts.size() == 3) begin
            chk("b2b_gap1", starts[1] - starts[0], 3);
            chk("b2b_gap2", starts[2] - starts[1], 3);
        end
        chk("b2b_evt0", evt_cnt[0], 2);
        chk("b2b_evt1", evt_cnt[1], 1);

        // random traffic
        rst_r = 1;
        step();
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NC; k++) begin
                if (!v[k] && $urandom_range(2) == 0) begin
                    v[k]  = 1'b1;
                    jv[k] = $urandom;
                end
            end
            d_r   = ($urandom_range(3) == 0);
            rst_r = ($urandom_range(199) == 0);
            clr_r = ($urandom_range(199) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
